voice_mixer: RTL

VOICE_MIXER -- requirements
Module: voice_mixer

---
 rtl/voice_mixer_pkg.sv | 29 ++
 rtl/voice_mixer_wave_shaper.sv | 33 +++
 rtl/voice_mixer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/voice_mixer_pkg.sv
// voice_mixer_pkg
// Shared definitions for the voice mixer:
//   - wave_type_e : waveform select encodings (SAW, SQUARE, TRI, NOISE)
//   - state_e     : mixer FSM states (IDLE, ACCUM, NORM)
//   - LFSR_SEED / LFSR_TAPS and lfsr_next() for the shared noise source
package voice_mixer_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_NOISE  = 2'd3
  } wave_type_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_NORM  = 2'd2
  } state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Galois form of x^16 + x^14 + x^13 + x^11 + 1 (right-shifting)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/voice_mixer_wave_shaper.sv
// wave_shaper
// Combinational raw-sample generator for one voice.
//   phase_top_i  : top WAVE_DEPTH bits of the voice phase accumulator
//   wave_type_i  : waveform select
//   noise_i      : low WAVE_DEPTH bits of the shared LFSR
//   wave_o       : raw unsigned sample W
module wave_shaper
  import voice_mixer_pkg::*;
#(
  parameter int WAVE_DEPTH = 8
) (
  input  logic [WAVE_DEPTH-1:0] phase_top_i,
  input  wave_type_e            wave_type_i,
  input  logic [WAVE_DEPTH-1:0] noise_i,
  output logic [WAVE_DEPTH-1:0] wave_o
);

  logic msb_w;
  assign msb_w = phase_top_i[WAVE_DEPTH-1];

  always_comb begin
    wave_o = '0;
    case (wave_type_i)
      WAVE_SAW:    wave_o = phase_top_i;
      WAVE_SQUARE: wave_o = {WAVE_DEPTH{msb_w}};
      // Rising ramp at double rate in the first half, mirrored in the second
      WAVE_TRI:    wave_o = {phase_top_i[WAVE_DEPTH-2:0], 1'b0} ^ {WAVE_DEPTH{msb_w}};
      WAVE_NOISE:  wave_o = noise_i;
      default:     wave_o = '0;
    endcase
  end

endmodule

// File: rtl/voice_mixer.sv
// voice_mixer
// Time-multiplexed wavetable mixer: on each sample tick, walks all voices
// one per cycle, shapes each voice's waveform, scales it by its gain and
// sums into an accumulator, then rescales the sum onto the output.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   sample_tick_i        : request for the next mixed sample
//   cfg_write_i          : write cfg_* fields into voice cfg_voice_i
//   cfg_voice_i          : target voice index
//   cfg_incr_i           : phase increment per sample
//   cfg_wave_type_i      : 0 saw, 1 square, 2 triangle, 3 noise
//   cfg_gain_i           : unsigned linear gain (255 ~ unity)
//   cfg_enable_i         : voice enable
//   waveform_o           : mixed, rescaled sample
//   sample_valid_o       : one-cycle strobe for a new waveform_o value
//   busy_o               : sample computation in progress
//   overrun_o            : sticky, tick arrived while busy
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int WAVE_DEPTH  = 8,
  parameter int NUM_VOICES  = 4,
  parameter int PHASE_WIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          sample_tick_i,
  input  logic                          cfg_write_i,
  input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice_i,
  input  logic [PHASE_WIDTH-1:0]        cfg_incr_i,
  input  logic [1:0]                    cfg_wave_type_i,
  input  logic [7:0]                    cfg_gain_i,
  input  logic                          cfg_enable_i,
  output logic [WAVE_DEPTH-1:0]         waveform_o,
  output logic                          sample_valid_o,
  output logic                          busy_o,
  output logic                          overrun_o
);

  localparam int IDX_W  = $clog2(NUM_VOICES);
  localparam int SHIFT  = 8 + IDX_W;
  localparam int ACC_W  = WAVE_DEPTH + SHIFT;
  localparam int PROD_W = WAVE_DEPTH + 8;

  state_e                  state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        acc_d;
  logic [15:0]             lfsr_q;
  logic [WAVE_DEPTH-1:0]   waveform_q;
  logic                    pend_q;
  logic                    valid_q;
  logic                    busy_q;
  logic                    overrun_q;

  // Per-voice state flattened into arrays for the voice-select mux
  logic [PHASE_WIDTH-1:0]  voice_phase [NUM_VOICES];
  logic [PHASE_WIDTH-1:0]  voice_incr  [NUM_VOICES];
  wave_type_e              voice_type  [NUM_VOICES];
  logic [7:0]              voice_gain  [NUM_VOICES];
  logic                    voice_en    [NUM_VOICES];

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    logic [PHASE_WIDTH-1:0] incr_q;
    logic [PHASE_WIDTH-1:0] phase_q;
    wave_type_e             type_q;
    logic [7:0]             gain_q;
    logic                   en_q;
    logic                   sel_w;
    logic                   proc_w;

    assign sel_w  = cfg_write_i && (cfg_voice_i == IDX_W'(gi));
    assign proc_w = (state_q == ST_ACCUM) && (idx_q == IDX_W'(gi));

    // A write landing on the edge that consumes this voice still leaves the
    // current sample computed from the old register values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        incr_q  <= '0;
        phase_q <= '0;
        type_q  <= WAVE_SAW;
        gain_q  <= '0;
        en_q    <= 1'b0;
      end else begin
        if (sel_w) begin
          incr_q <= cfg_incr_i;
          type_q <= wave_type_e'(cfg_wave_type_i);
          gain_q <= cfg_gain_i;
          en_q   <= cfg_enable_i;
        end
        if (!en_q) begin
          phase_q <= '0;
        end else if (proc_w) begin
          phase_q <= phase_q + incr_q;
        end
      end
    end

    assign voice_phase[gi] = phase_q;
    assign voice_incr[gi]  = incr_q;
    assign voice_type[gi]  = type_q;
    assign voice_gain[gi]  = gain_q;
    assign voice_en[gi]    = en_q;
  end

  logic [WAVE_DEPTH-1:0] wave_w;
  logic [PROD_W-1:0]     prod_w;

  wave_shaper #(
    .WAVE_DEPTH (WAVE_DEPTH)
  ) u_wave_shaper (
    .phase_top_i (voice_phase[idx_q][PHASE_WIDTH-1 -: WAVE_DEPTH]),
    .wave_type_i (voice_type[idx_q]),
    .noise_i     (lfsr_q[WAVE_DEPTH-1:0]),
    .wave_o      (wave_w)
  );

  assign prod_w = voice_en[idx_q] ? (PROD_W'(wave_w) * PROD_W'(voice_gain[idx_q])) : '0;
  assign acc_d  = acc_q + ACC_W'(prod_w);

  // pend_q marks the NORM update; the strobe follows one edge later while
  // waveform_q is already holding the new value.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      acc_q      <= '0;
      lfsr_q     <= LFSR_SEED;
      waveform_q <= '0;
      pend_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      valid_q <= pend_q;
      pend_q  <= 1'b0;
      if (sample_tick_i && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        ST_IDLE: begin
          if (sample_tick_i) begin
            state_q <= ST_ACCUM;
            idx_q   <= '0;
            acc_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_ACCUM: begin
          acc_q  <= acc_d;
          lfsr_q <= lfsr_next(lfsr_q);
          if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
            state_q <= ST_NORM;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_NORM: begin
          // Sum of NUM_VOICES products of 8-bit gain cannot exceed ACC_W bits
          waveform_q <= WAVE_DEPTH'(acc_q >> SHIFT);
          pend_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign waveform_o     = waveform_q;
  assign sample_valid_o = valid_q;
  assign busy_o         = busy_q;
  assign overrun_o      = overrun_q;

endmodule
